// File: rtl/control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the RV32I datapath.
// Define CTRL_TRAP_EN to trap on illegal encodings; otherwise they execute as NOP.
module control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       eq,
    input  logic       a_lt_b,
    input  logic       a_lt_ub,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       insn_we,
    output logic       rd_we,
    output logic       pc_we,
    output logic [1:0] rd_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic       pc_alu_sel,
    output logic       pc_next_sel,
    output logic [3:0] alu_func,
    output logic [2:0] sx_size,
    output logic       trap,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_TRAP   = 3'd4
    } state_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_SLL = 4'd2, F_SLT = 4'd3;
    localparam logic [3:0] F_SLTU = 4'd4, F_XOR = 4'd5, F_SRL = 4'd6, F_SRA = 4'd7;
    localparam logic [3:0] F_OR = 4'd8, F_AND = 4'd9, F_PASS_B = 4'd10;

    state_t     state_q, state_d;
    logic [3:0] alu_fn;
    logic       br_ok, br_taken, illegal;
    logic       unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // func7[5] picks SUB only for register-register ops; shifts honour it for both forms
    always_comb begin
        alu_fn = F_ADD;
        case (func3)
            3'b000:  alu_fn = (opcode == OP_OP && func7[5]) ? F_SUB : F_ADD;
            3'b001:  alu_fn = F_SLL;
            3'b010:  alu_fn = F_SLT;
            3'b011:  alu_fn = F_SLTU;
            3'b100:  alu_fn = F_XOR;
            3'b101:  alu_fn = func7[5] ? F_SRA : F_SRL;
            3'b110:  alu_fn = F_OR;
            default: alu_fn = F_AND;
        endcase
    end

    always_comb begin
        br_ok    = 1'b1;
        br_taken = 1'b0;
        case (func3[2:1])
            2'b00:   br_taken = eq ^ func3[0];
            2'b10:   br_taken = a_lt_b ^ func3[0];
            2'b11:   br_taken = a_lt_ub ^ func3[0];
            default: br_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        illegal     = 1'b0;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        addr_sel    = 1'b0;
        insn_we     = 1'b0;
        rd_we       = 1'b0;
        pc_we       = 1'b0;
        rd_sel      = 2'd0;
        alu_a_sel   = 1'b0;
        alu_b_sel   = 1'b0;
        pc_alu_sel  = 1'b0;
        pc_next_sel = 1'b0;
        alu_func    = F_ADD;
        sx_size     = 3'd0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    insn_we = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_OP, OP_IMM: begin
                        alu_b_sel  = (opcode == OP_IMM);
                        alu_func   = alu_fn;
                        rd_sel     = 2'd1;
                        rd_we      = 1'b1;
                        pc_alu_sel = 1'b1;
                        pc_we      = 1'b1;
                    end
                    OP_LUI, OP_AUIPC: begin
                        alu_a_sel  = (opcode == OP_AUIPC);
                        alu_b_sel  = 1'b1;
                        alu_func   = (opcode == OP_LUI) ? F_PASS_B : F_ADD;
                        rd_sel     = 2'd1;
                        rd_we      = 1'b1;
                        pc_alu_sel = 1'b1;
                        pc_we      = 1'b1;
                    end
                    OP_JAL, OP_JALR: begin
                        alu_a_sel   = (opcode == OP_JAL);
                        alu_b_sel   = 1'b1;
                        pc_next_sel = 1'b1;
                        pc_we       = 1'b1;
                        pc_alu_sel  = 1'b1;
                        rd_we       = 1'b1;
                    end
                    OP_BRANCH: begin
                        if (br_ok) begin
                            alu_func   = F_SUB;
                            pc_alu_sel = !br_taken;
                            pc_we      = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_b_sel = 1'b1;
                        sx_size   = func3;
                        state_d   = S_MEM;
                    end
                    OP_MISC, OP_SYSTEM: begin
                        pc_alu_sel = 1'b1;
                        pc_we      = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
                if (illegal) begin
`ifdef CTRL_TRAP_EN
                    state_d = S_TRAP;
`else
                    pc_alu_sel = 1'b1;
                    pc_we      = 1'b1;
`endif
                end
            end
            S_MEM: begin
                alu_b_sel  = 1'b1;
                addr_sel   = 1'b1;
                mem_req    = 1'b1;
                mem_wr     = (opcode == OP_STORE);
                sx_size    = func3;
                pc_alu_sel = 1'b1;
                rd_sel     = (opcode == OP_LOAD) ? 2'd2 : 2'd0;
                if (mem_ready) begin
                    pc_we   = 1'b1;
                    rd_we   = (opcode == OP_LOAD);
                    state_d = S_FETCH;
                end
            end
`ifdef CTRL_TRAP_EN
            S_TRAP:  state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase

`ifdef CTRL_TRAP_EN
        trap  = (state_q == S_TRAP);
`else
        trap  = 1'b0;
`endif
        state = state_q;

        // Outputs are held at zero for as long as reset is asserted
        if (!rst_n) begin
            mem_req     = 1'b0;
            mem_wr      = 1'b0;
            addr_sel    = 1'b0;
            insn_we     = 1'b0;
            rd_we       = 1'b0;
            pc_we       = 1'b0;
            rd_sel      = 2'd0;
            alu_a_sel   = 1'b0;
            alu_b_sel   = 1'b0;
            pc_alu_sel  = 1'b0;
            pc_next_sel = 1'b0;
            alu_func    = 4'd0;
            sx_size     = 3'd0;
            trap        = 1'b0;
            state       = 3'd0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed scoreboard bench for control_fsm: expected output vectors are queued per cycle
// and compared against the DUT half a cycle away from the active edge.
module tb_control_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_wr;
        logic       addr_sel;
        logic       insn_we;
        logic       rd_we;
        logic       pc_we;
        logic [1:0] rd_sel;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic       pc_alu_sel;
        logic       pc_next_sel;
        logic [3:0] alu_func;
        logic [2:0] sx_size;
        logic       trap;
        logic [2:0] state;
    } outv_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       eq, a_lt_b, a_lt_ub, mem_ready;
    logic       mem_req, mem_wr, addr_sel, insn_we, rd_we, pc_we;
    logic [1:0] rd_sel;
    logic       alu_a_sel, alu_b_sel, pc_alu_sel, pc_next_sel;
    logic [3:0] alu_func;
    logic [2:0] sx_size;
    logic       trap;
    logic [2:0] state;

    outv_t dut_out;
    outv_t exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    outv_t e;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
        .eq(eq), .a_lt_b(a_lt_b), .a_lt_ub(a_lt_ub), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_wr(mem_wr), .addr_sel(addr_sel), .insn_we(insn_we),
        .rd_we(rd_we), .pc_we(pc_we), .rd_sel(rd_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .pc_alu_sel(pc_alu_sel), .pc_next_sel(pc_next_sel),
        .alu_func(alu_func), .sx_size(sx_size), .trap(trap), .state(state)
    );

    assign dut_out = {mem_req, mem_wr, addr_sel, insn_we, rd_we, pc_we, rd_sel,
                      alu_a_sel, alu_b_sel, pc_alu_sel, pc_next_sel, alu_func,
                      sx_size, trap, state};

    function automatic outv_t st(input logic [2:0] s);
        outv_t v;
        v = '0;
        v.state = s;
        return v;
    endfunction

    function automatic outv_t wb(input logic [3:0] fn, input logic a, input logic b);
        outv_t v;
        v = st(3'd2);
        v.rd_sel     = 2'd1;
        v.rd_we      = 1'b1;
        v.pc_we      = 1'b1;
        v.pc_alu_sel = 1'b1;
        v.alu_func   = fn;
        v.alu_a_sel  = a;
        v.alu_b_sel  = b;
        return v;
    endfunction

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic chk(input string tag, input outv_t ev);
        outv_t ex;
        string t;
        exp_q.push_back(ev);
        tag_q.push_back(tag);
        #1;
        ex = exp_q.pop_front();
        t  = tag_q.pop_front();
        n_cmp++;
        assert (dut_out === ex) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", t, dut_out, ex);
        end
        @(negedge clk);
    endtask

    task automatic fetch_decode(input string tag);
        outv_t v;
        mem_ready = 1'b1;
        v = st(3'd0);
        v.mem_req = 1'b1;
        v.insn_we = 1'b1;
        chk({tag, "_fetch"}, v);
        chk({tag, "_decode"}, st(3'd1));
    endtask

    task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input outv_t ex_exec);
        opcode = op;
        func3  = f3;
        func7  = f7;
        fetch_decode(tag);
        chk({tag, "_exec"}, ex_exec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; opcode = 7'd0; func3 = 3'd0; func7 = 7'd0;
        eq = 1'b0; a_lt_b = 1'b0; a_lt_ub = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("reset0", '0);
        chk("reset1", '0);
        rst_n = 1'b1;

        run("addi",  7'b0010011, 3'b000, 7'b0000000, wb(4'd0, 1'b0, 1'b1));
        run("sub",   7'b0110011, 3'b000, 7'b0100000, wb(4'd1, 1'b0, 1'b0));
        run("add",   7'b0110011, 3'b000, 7'b0000000, wb(4'd0, 1'b0, 1'b0));
        run("addi7", 7'b0010011, 3'b000, 7'b0100000, wb(4'd0, 1'b0, 1'b1));
        run("srai",  7'b0010011, 3'b101, 7'b0100000, wb(4'd7, 1'b0, 1'b1));
        run("srli",  7'b0010011, 3'b101, 7'b0000000, wb(4'd6, 1'b0, 1'b1));
        run("sltu",  7'b0110011, 3'b011, 7'b0000000, wb(4'd4, 1'b0, 1'b0));
        run("and",   7'b0110011, 3'b111, 7'b0000000, wb(4'd9, 1'b0, 1'b0));
        run("lui",   7'b0110111, 3'b000, 7'b0000000, wb(4'd10, 1'b0, 1'b1));
        run("auipc", 7'b0010111, 3'b000, 7'b0000000, wb(4'd0, 1'b1, 1'b1));

        eq = 1'b0;
        e = st(3'd2); e.alu_func = 4'd1; e.pc_we = 1'b1; e.pc_alu_sel = 1'b0;
        run("bne_taken", 7'b1100011, 3'b001, 7'd0, e);
        eq = 1'b1;
        e = st(3'd2); e.alu_func = 4'd1; e.pc_we = 1'b1; e.pc_alu_sel = 1'b1;
        run("bne_not", 7'b1100011, 3'b001, 7'd0, e);
        a_lt_b = 1'b1;
        e = st(3'd2); e.alu_func = 4'd1; e.pc_we = 1'b1; e.pc_alu_sel = 1'b0;
        run("blt_taken", 7'b1100011, 3'b100, 7'd0, e);
        a_lt_ub = 1'b0;
        e = st(3'd2); e.alu_func = 4'd1; e.pc_we = 1'b1; e.pc_alu_sel = 1'b0;
        run("bgeu_taken", 7'b1100011, 3'b111, 7'd0, e);
        eq = 1'b0; a_lt_b = 1'b0;

        e = st(3'd2); e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1; e.pc_next_sel = 1'b1;
        e.pc_we = 1'b1; e.pc_alu_sel = 1'b1; e.rd_we = 1'b1;
        run("jal", 7'b1101111, 3'b000, 7'd0, e);
        e.alu_a_sel = 1'b0;
        run("jalr", 7'b1100111, 3'b000, 7'd0, e);

        e = st(3'd2); e.pc_we = 1'b1; e.pc_alu_sel = 1'b1;
        run("fence", 7'b0001111, 3'b000, 7'd0, e);

        e = st(3'd2); e.alu_b_sel = 1'b1; e.sx_size = 3'b010;
        run("lw", 7'b0000011, 3'b010, 7'd0, e);
        mem_ready = 1'b0;
        e = st(3'd3); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.alu_b_sel = 1'b1;
        e.sx_size = 3'b010; e.rd_sel = 2'd2; e.pc_alu_sel = 1'b1;
        chk("lw_mem_wait1", e);
        chk("lw_mem_wait2", e);
        mem_ready = 1'b1;
        e.rd_we = 1'b1; e.pc_we = 1'b1;
        chk("lw_mem_ready", e);

        e = st(3'd2); e.alu_b_sel = 1'b1; e.sx_size = 3'b010;
        run("sw", 7'b0100011, 3'b010, 7'd0, e);
        e = st(3'd3); e.mem_req = 1'b1; e.mem_wr = 1'b1; e.addr_sel = 1'b1; e.alu_b_sel = 1'b1;
        e.sx_size = 3'b010; e.pc_alu_sel = 1'b1; e.pc_we = 1'b1;
        chk("sw_mem", e);

        mem_ready = 1'b0;
        e = st(3'd0); e.mem_req = 1'b1;
        chk("fetch_wait1", e);
        chk("fetch_wait2", e);
        rst_n = 1'b0;
        chk("rst_in_fetch", '0);
        rst_n = 1'b1;
        chk("after_rst_fetch", e);

        e = st(3'd2); e.alu_b_sel = 1'b1; e.sx_size = 3'b010;
        run("lw2", 7'b0000011, 3'b010, 7'd0, e);
        mem_ready = 1'b0;
        e = st(3'd3); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.alu_b_sel = 1'b1;
        e.sx_size = 3'b010; e.rd_sel = 2'd2; e.pc_alu_sel = 1'b1;
        chk("lw2_mem_wait", e);
        rst_n = 1'b0;
        chk("rst_in_mem", '0);
        rst_n = 1'b1;
        e = st(3'd0); e.mem_req = 1'b1;
        chk("after_rst_mem", e);

`ifdef CTRL_TRAP_EN
        run("illegal", 7'b1111111, 3'b000, 7'd0, st(3'd2));
        e = st(3'd4); e.trap = 1'b1;
        for (int i = 0; i < 10; i++) chk("trap_hold", e);
`else
        e = st(3'd2); e.pc_we = 1'b1; e.pc_alu_sel = 1'b1;
        run("bad_branch", 7'b1100011, 3'b010, 7'd0, e);
        run("illegal", 7'b1111111, 3'b000, 7'd0, e);
        e = st(3'd0); e.mem_req = 1'b1; e.insn_we = 1'b1;
        chk("illegal_next_fetch", e);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
